// File: rtl/node_route_sequencer_pkg.sv
// Shared route definitions: turn/action codes, FSM states, entry helpers.
// Imported by the route sequencer and its sub-blocks.
package route_pkg;

    typedef enum logic [1:0] {
        TURN_UTURN    = 2'b00,
        TURN_LEFT     = 2'b01,
        TURN_RIGHT    = 2'b10,
        TURN_STRAIGHT = 2'b11
    } turn_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_PICK  = 2'b01,
        ACT_PLACE = 2'b10,
        ACT_END   = 2'b11
    } act_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_OP,
        S_TURNING,
        S_DONE
    } state_t;

    localparam logic [2:0] PAT_NODE = 3'b111;

    function automatic turn_t entry_turn(input logic [3:0] e);
        return turn_t'(e[1:0]);
    endfunction

    function automatic act_t entry_act(input logic [3:0] e);
        return act_t'(e[3:2]);
    endfunction

    // Single centred/offset bit means the follower has the line again.
    function automatic logic is_line(input logic [2:0] s);
        return (s == 3'b010) || (s == 3'b001) || (s == 3'b100);
    endfunction

endpackage

// File: rtl/node_route_sequencer_if.sv
// Bus between the route sequencer and its environment:
// sensor/control inputs, table write port, follower-facing outputs.
interface node_route_sequencer_if #(
    parameter int AW = 4
);
    logic [2:0]    line_sensor;
    logic          robot_enabled;
    logic          start;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic [1:0]    turn_direction;
    logic          activate_pick_operation;
    logic          activate_place_operation;
    logic          route_done;
    logic          busy;
    logic [AW-1:0] node_count;

    modport master (
        output line_sensor, robot_enabled, start,
        output wr_en, wr_addr, wr_data,
        input  turn_direction, activate_pick_operation,
        input  activate_place_operation, route_done,
        input  busy, node_count
    );

    modport slave (
        input  line_sensor, robot_enabled, start,
        input  wr_en, wr_addr, wr_data,
        output turn_direction, activate_pick_operation,
        output activate_place_operation, route_done,
        output busy, node_count
    );
endinterface

// File: rtl/node_route_sequencer_pattern_debounce.sv
// Counts consecutive enabled cycles of a match input; pulses hit on the
// N-th one and restarts. Any miss or disable clears the run.
module pattern_debounce #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic match,
    output logic hit
);
    localparam int W = (N < 2) ? 1 : $clog2(N);

    logic [W-1:0] cnt_q;

    assign hit = en && match && (cnt_q == W'(N - 1));

    // Run counter: advances on each matching cycle, clears on miss or hit.
    always_ff @(posedge clk) begin
        if (reset || !en || !match || hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/node_route_sequencer.sv
// Route planner feeding the line follower: walks a preloaded turn/action
// table, one entry per debounced node, with timed pick/place requests.
module node_route_sequencer
    import route_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int DEBOUNCE  = 4,
    parameter int CLEAR     = 4,
    parameter int OP_CYCLES = 50_000_000,
    parameter int OPW       = 26
) (
    input logic clk,
    input logic reset,
    node_route_sequencer_if.slave bus
);
    logic [3:0]    table_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] node_q, node_d;
    logic [OPW-1:0] op_q, op_d;
    logic [1:0]    turn_q, turn_d;
    logic          pick_q, pick_d;
    logic          place_q, place_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          en;
    logic          node_hit;
    logic          line_hit;
    logic          op_last;
    logic          ptr_last;
    logic [3:0]    cur;
    act_t          cur_act;

    assign en       = bus.robot_enabled;
    assign cur      = table_q[ptr_q];
    assign cur_act  = entry_act(cur);
    assign op_last  = (op_q == OPW'(OP_CYCLES - 1));
    assign ptr_last = (ptr_q == AW'(DEPTH - 1));

    pattern_debounce #(.N(DEBOUNCE)) u_node (
        .clk   (clk),
        .reset (reset),
        .en    (en && (state_q == S_SEEK)),
        .match (bus.line_sensor == PAT_NODE),
        .hit   (node_hit)
    );

    pattern_debounce #(.N(CLEAR)) u_line (
        .clk   (clk),
        .reset (reset),
        .en    (en && (state_q == S_TURNING)),
        .match (is_line(bus.line_sensor)),
        .hit   (line_hit)
    );

    // Route table: written only while idle, never reset.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_IDLE) && bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a disabled robot freezes the sequence.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) state_d = S_SEEK;
                end
                S_SEEK: begin
                    if (node_hit) begin
                        unique case (1'b1)
                            (cur_act == ACT_PICK),
                            (cur_act == ACT_PLACE): state_d = S_OP;
                            (cur_act == ACT_END):   state_d = S_DONE;
                            default:                state_d = S_TURNING;
                        endcase
                    end
                end
                S_OP: begin
                    if (op_last) state_d = S_TURNING;
                end
                S_TURNING: begin
                    if (line_hit) state_d = ptr_last ? S_DONE : S_SEEK;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        ptr_d   = ptr_q;
        node_d  = node_q;
        op_d    = op_q;
        pick_d  = pick_q;
        place_d = place_q;
        if (en) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        ptr_d  = '0;
                        node_d = '0;
                    end
                end
                S_SEEK: begin
                    if (node_hit) begin
                        node_d  = node_q + 1'b1;
                        op_d    = '0;
                        pick_d  = (cur_act == ACT_PICK);
                        place_d = (cur_act == ACT_PLACE);
                    end
                end
                S_OP: begin
                    if (op_last) begin
                        pick_d  = 1'b0;
                        place_d = 1'b0;
                    end else begin
                        op_d = op_q + 1'b1;
                    end
                end
                S_TURNING: begin
                    if (line_hit && !ptr_last) ptr_d = ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
        busy_d = (state_d == S_SEEK) || (state_d == S_OP) ||
                 (state_d == S_TURNING);
        done_d = (state_d == S_DONE);
        turn_d = ((state_q == S_IDLE) || (state_q == S_DONE)) ?
                 TURN_STRAIGHT : entry_turn(cur);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            node_q  <= '0;
            op_q    <= '0;
            turn_q  <= TURN_STRAIGHT;
            pick_q  <= 1'b0;
            place_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            node_q  <= node_d;
            op_q    <= op_d;
            turn_q  <= turn_d;
            pick_q  <= pick_d;
            place_q <= place_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.turn_direction           = turn_q;
    assign bus.activate_pick_operation  = pick_q;
    assign bus.activate_place_operation = place_q;
    assign bus.route_done               = done_q;
    assign bus.busy                     = busy_q;
    assign bus.node_count               = node_q;
endmodule

// File: tb/tb_node_route_sequencer.sv
// Randomised and directed bench for node_route_sequencer against a
// behavioural route model.
module tb_node_route_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DEB   = 4;
    localparam int CLR   = 4;
    localparam int OPC   = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    node_route_sequencer_if #(.AW(AW)) bus ();

    node_route_sequencer #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DEBOUNCE  (DEB),
        .CLEAR     (CLR),
        .OP_CYCLES (OPC),
        .OPW       (26)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 seek, 2 op, 3 turning, 4 done.
    int         m_mode;
    int         m_idx;
    int         m_r111;
    int         m_rline;
    int         m_opl;
    logic [3:0] m_tab [DEPTH];
    logic [1:0] e_turn;
    logic       e_pick, e_place, e_done, e_busy;
    logic [3:0] e_nodes;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        int act;
        int s;
        if (reset) begin
            m_mode = 0; m_idx = 0; m_r111 = 0; m_rline = 0; m_opl = 0;
            e_turn = 2'b11; e_pick = 0; e_place = 0;
            e_done = 0; e_busy = 0; e_nodes = 0;
            return;
        end
        e_turn = (m_mode == 0 || m_mode == 4) ? 2'b11 : m_tab[m_idx][1:0];
        if (m_mode == 0 && bus.wr_en) m_tab[bus.wr_addr] = bus.wr_data;
        s = int'(bus.line_sensor);
        if (!bus.robot_enabled) begin
            m_r111 = 0;
            m_rline = 0;
        end else begin
            case (m_mode)
                0, 4: if (bus.start) begin
                    m_mode = 1; m_idx = 0; e_nodes = 0; m_r111 = 0;
                end
                1: begin
                    m_r111 = (s == 7) ? m_r111 + 1 : 0;
                    if (m_r111 == DEB) begin
                        m_r111 = 0;
                        e_nodes = e_nodes + 1;
                        act = int'(m_tab[m_idx][3:2]);
                        if (act == 1 || act == 2) begin
                            m_mode = 2; m_opl = OPC;
                            e_pick = (act == 1); e_place = (act == 2);
                        end else if (act == 3) begin
                            m_mode = 4;
                        end else begin
                            m_mode = 3; m_rline = 0;
                        end
                    end
                end
                2: begin
                    m_opl--;
                    if (m_opl == 0) begin
                        e_pick = 0; e_place = 0;
                        m_mode = 3; m_rline = 0;
                    end
                end
                3: begin
                    m_rline = (s == 1 || s == 2 || s == 4) ? m_rline + 1 : 0;
                    if (m_rline == CLR) begin
                        m_rline = 0;
                        if (m_idx == DEPTH - 1) begin
                            m_mode = 4;
                        end else begin
                            m_idx++; m_mode = 1; m_r111 = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
        e_busy = (m_mode >= 1 && m_mode <= 3);
        e_done = (m_mode == 4);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("turn",  32'(bus.turn_direction),           32'(e_turn));
        chk("pick",  32'(bus.activate_pick_operation),  32'(e_pick));
        chk("place", 32'(bus.activate_place_operation), 32'(e_place));
        chk("done",  32'(bus.route_done),               32'(e_done));
        chk("busy",  32'(bus.busy),                     32'(e_busy));
        chk("nodes", 32'(bus.node_count),               32'(e_nodes));
    endtask

    task automatic sense(input logic [2:0] p, input int n);
        bus.line_sensor = p;
        repeat (n) cyc();
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    logic [2:0] pats [9] = '{3'b111, 3'b111, 3'b010, 3'b001, 3'b100,
                             3'b000, 3'b011, 3'b110, 3'b101};

    initial begin
        int cnt;
        int cnt2;
        logic [1:0] t0;
        logic [3:0] d;
        reset = 1'b1;
        bus.line_sensor = 3'b000;
        bus.robot_enabled = 1'b1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        do_reset(3);
        chk("rst_turn", 32'(bus.turn_direction), 32'h3);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        for (int i = 0; i < DEPTH; i++) wr(i, 4'($urandom_range(0, 3)));

        wr(0, 4'b0001);
        wr(1, 4'b0010);
        wr(2, 4'b1111);
        go();
        sense(3'b111, 4);
        chk("s1_turn0", 32'(bus.turn_direction), 32'h1);
        sense(3'b010, 4);
        sense(3'b111, 4);
        chk("s1_turn1", 32'(bus.turn_direction), 32'h2);
        sense(3'b010, 4);
        sense(3'b111, 4);
        chk("s1_done", 32'(bus.route_done), 32'h1);
        chk("s1_nodes", 32'(bus.node_count), 32'h3);
        sense(3'b000, 2);
        chk("s1_turn_done", 32'(bus.turn_direction), 32'h3);

        go();
        sense(3'b111, 3);
        sense(3'b010, 1);
        chk("s2_nodes", 32'(bus.node_count), 32'h0);
        chk("s2_busy", 32'(bus.busy), 32'h1);
        chk("s2_turn", 32'(bus.turn_direction), 32'h1);
        sense(3'b000, 2);

        do_reset(1);
        wr(0, 4'b0111);
        wr(1, 4'b1001);
        wr(2, 4'b0110);
        go();
        sense(3'b111, 4);
        cnt = bus.activate_pick_operation ? 1 : 0;
        cnt2 = 0;
        bus.line_sensor = 3'b000;
        repeat (11) begin
            cyc();
            cnt += bus.activate_pick_operation ? 1 : 0;
            cnt2 += bus.activate_place_operation ? 1 : 0;
        end
        chk("s3_pick_len", 32'(cnt), 32'd8);
        chk("s3_place_len", 32'(cnt2), 32'd0);
        sense(3'b010, 4);
        sense(3'b000, 1);
        chk("s3_turn", 32'(bus.turn_direction), 32'h1);

        sense(3'b111, 4);
        cnt = bus.activate_place_operation ? 1 : 0;
        bus.line_sensor = 3'b000;
        repeat (2) begin
            cyc();
            cnt += bus.activate_place_operation ? 1 : 0;
        end
        bus.robot_enabled = 1'b0;
        repeat (5) begin
            cyc();
            cnt += bus.activate_place_operation ? 1 : 0;
        end
        bus.robot_enabled = 1'b1;
        repeat (10) begin
            cyc();
            cnt += bus.activate_place_operation ? 1 : 0;
        end
        chk("s4_place_len", 32'(cnt), 32'd13);
        sense(3'b010, 4);

        sense(3'b111, 4);
        sense(3'b000, 2);
        do_reset(1);
        chk("s5_pick", 32'(bus.activate_pick_operation), 32'h0);
        chk("s5_turn", 32'(bus.turn_direction), 32'h3);
        chk("s5_busy", 32'(bus.busy), 32'h0);
        go();
        wr(0, 4'b1111);
        sense(3'b111, 4);
        chk("s5_tab_kept", 32'(bus.activate_pick_operation), 32'h1);
        sense(3'b000, 10);
        sense(3'b010, 4);

        do_reset(1);
        for (int i = 0; i < DEPTH; i++) wr(i, {2'b00, 2'($urandom_range(0, 3))});
        t0 = m_tab[0][1:0];
        go();
        for (int i = 0; i < DEPTH; i++) begin
            sense(3'b111, 4);
            sense(3'b010, 4);
        end
        chk("s6_done", 32'(bus.route_done), 32'h1);
        chk("s6_nodes", 32'(bus.node_count), 32'h0);
        go();
        chk("s6_restart", 32'(bus.busy), 32'h1);
        cyc();
        chk("s6_turn0", 32'(bus.turn_direction), 32'(t0));

        do_reset(1);
        for (int i = 0; i < DEPTH; i++) begin
            d[1:0] = 2'($urandom_range(0, 3));
            d[3:2] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            wr(i, d);
        end
        go();
        for (int seg = 0; seg < 500; seg++) begin
            bus.line_sensor = pats[$urandom_range(0, 8)];
            repeat ($urandom_range(1, 6)) begin
                bus.robot_enabled = ($urandom_range(0, 9) != 0);
                bus.start = ($urandom_range(0, 19) == 0);
                bus.wr_en = ($urandom_range(0, 7) == 0);
                bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.wr_data = 4'($urandom_range(0, 15));
                reset = ($urandom_range(0, 299) == 0);
                cyc();
            end
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
